// File: rtl/func_vector_sweeper.sv
// ---------------------------------------------------------------------------
// func_vector_sweeper
//
// Stimulus/capture stage for a 4-input combinational function block. When a
// start is accepted it walks vec through 0..15 and holds each value for
// SETTLE_CYCLES clocks. On the last clock of each hold period it samples
// f_in into captured[vec]. Each sample is also compared against EXPECTED[vec],
// and the stage keeps a mismatch count and the lowest failing vector.
// When the final vector has been sampled it pulses done for one cycle.
//
// Handshake: start is a level request and busy is its not-ready indication.
// A start is accepted on any rising edge where start==1 and busy==0. That
// covers the IDLE state and the one-cycle DONE state. While busy==1, start
// is ignored entirely. A start held high therefore re-triggers immediately
// after each sweep completes.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset (aborts a sweep, no done)
//   start         in   1   begin sweep; sampled only while busy==0
//   f_in          in   1   function block output (combinational from vec)
//   vec           out  4   drive to function block: A=vec[3] B=vec[2] C=vec[1] D=vec[0]
//   busy          out  1   sweep in progress
//   done          out  1   one-cycle pulse: sweep complete, results final
//   captured      out  16  bit n = f_in sampled while vec==n
//   pass          out  1   captured==EXPECTED; valid from done until next start
//   mismatch_cnt  out  5   number of mismatching bits (0..16)
//   fail_valid    out  1   at least one mismatch recorded
//   fail_idx      out  4   lowest mismatching vec; 0 when fail_valid==0
//   state_dbg     out  2   current FSM state (0=IDLE, 1=DRIVE, 2=DONE)
// ---------------------------------------------------------------------------
module func_vector_sweeper #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] EXPECTED      = 16'h754B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic        fail_valid,
    output logic [3:0]  fail_idx,
    output logic [1:0]  state_dbg
);

    // A one-cycle settle period still needs a 1-bit counter; it simply stays 0.
    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    vec_n;
    logic          busy_n;
    logic          done_n;
    logic [15:0]   captured_n;
    logic          pass_n;
    logic [4:0]    mismatch_cnt_n;
    logic          fail_valid_n;
    logic [3:0]    fail_idx_n;

    logic          sample_now;
    logic          sample_miss;

    assign state_dbg   = state;
    assign sample_now  = (state == ST_DRIVE) && (cnt == CNT_LAST);
    assign sample_miss = (f_in != EXPECTED[vec]);

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            vec          <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            captured     <= 16'd0;
            pass         <= 1'b0;
            mismatch_cnt <= 5'd0;
            fail_valid   <= 1'b0;
            fail_idx     <= 4'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            vec          <= vec_n;
            busy         <= busy_n;
            done         <= done_n;
            captured     <= captured_n;
            pass         <= pass_n;
            mismatch_cnt <= mismatch_cnt_n;
            fail_valid   <= fail_valid_n;
            fail_idx     <= fail_idx_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        vec_n          = vec;
        busy_n         = busy;
        done_n         = 1'b0;
        captured_n     = captured;
        pass_n         = pass;
        mismatch_cnt_n = mismatch_cnt;
        fail_valid_n   = fail_valid;
        fail_idx_n     = fail_idx;

        case (state)
            // IDLE and DONE both accept a start. Accepting a start from DONE
            // gives back-to-back sweeps with no idle cycle between them.
            ST_IDLE, ST_DONE: begin
                state_n = ST_IDLE;
                if (start) begin
                    state_n        = ST_DRIVE;
                    cnt_n          = '0;
                    vec_n          = 4'd0;
                    busy_n         = 1'b1;
                    captured_n     = 16'd0;
                    pass_n         = 1'b0;
                    mismatch_cnt_n = 5'd0;
                    fail_valid_n   = 1'b0;
                    fail_idx_n     = 4'd0;
                end
            end

            ST_DRIVE: begin
                if (sample_now) begin
                    cnt_n           = '0;
                    captured_n[vec] = f_in;
                    if (sample_miss) begin
                        mismatch_cnt_n = mismatch_cnt + 5'd1;
                        if (!fail_valid) begin
                            fail_valid_n = 1'b1;
                            fail_idx_n   = vec;
                        end
                    end
                    if (vec == 4'd15) begin
                        // vec stays at 15; pass includes this last sample.
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        pass_n  = (mismatch_cnt_n == 5'd0);
                    end else begin
                        vec_n = vec + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_func_vector_sweeper.sv
// ---------------------------------------------------------------------------
// tb_func_vector_sweeper
//
// Two instances share clk/rst: u_dut4 (SETTLE_CYCLES=4) and u_dut1
// (SETTLE_CYCLES=1). Each instance sees a function block modelled as a truth
// table lookup, f_in = tbl[vec]. The reference model derives the expected
// results directly from tbl: captured equals tbl, the mismatch count is the
// popcount of tbl^EXPECTED, and fail_idx is the lowest differing bit. Vector
// timing is derived from elapsed cycles since the accepting edge.
// ---------------------------------------------------------------------------
module tb_func_vector_sweeper;

  localparam logic [15:0] EXP = 16'h754B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus state ----------------
  logic        start_r = 1'b0;
  logic        sel     = 1'b0;   // 0: u_dut4, 1: u_dut1
  logic [15:0] tbl     = EXP;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- DUT wiring ----------------
  logic        start4, f_in4, busy4, done4, pass4, fv4;
  logic [3:0]  vec4, fi4;
  logic [15:0] cap4;
  logic [4:0]  mc4;
  logic [1:0]  st4;

  logic        start1, f_in1, busy1, done1, pass1, fv1;
  logic [3:0]  vec1, fi1;
  logic [15:0] cap1;
  logic [4:0]  mc1;
  logic [1:0]  st1;

  assign start4 = start_r & ~sel;
  assign start1 = start_r & sel;
  assign f_in4  = tbl[vec4];
  assign f_in1  = tbl[vec1];

  func_vector_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(EXP)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .f_in(f_in4),
    .vec(vec4), .busy(busy4), .done(done4), .captured(cap4), .pass(pass4),
    .mismatch_cnt(mc4), .fail_valid(fv4), .fail_idx(fi4), .state_dbg(st4)
  );

  func_vector_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f_in1),
    .vec(vec1), .busy(busy1), .done(done1), .captured(cap1), .pass(pass1),
    .mismatch_cnt(mc1), .fail_valid(fv1), .fail_idx(fi1), .state_dbg(st1)
  );

  // Observed view of whichever instance is selected.
  logic        o_busy, o_done, o_pass, o_fv;
  logic [3:0]  o_vec, o_fi;
  logic [15:0] o_cap;
  logic [4:0]  o_mc;
  logic [1:0]  o_st;

  always_comb begin
    o_busy = sel ? busy1 : busy4;
    o_done = sel ? done1 : done4;
    o_pass = sel ? pass1 : pass4;
    o_fv   = sel ? fv1   : fv4;
    o_vec  = sel ? vec1  : vec4;
    o_fi   = sel ? fi1   : fi4;
    o_cap  = sel ? cap1  : cap4;
    o_mc   = sel ? mc1   : mc4;
    o_st   = sel ? st1   : st4;
  end

  // ---------------- scoreboard ----------------
  // Packed result: {captured[15:0], mismatch_cnt[4:0], fail_valid, fail_idx[3:0], pass}
  logic [26:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [26:0] model(input logic [15:0] t);
    logic [15:0] diff;
    int          cnt;
    logic        fv;
    logic [3:0]  idx;
    diff = t ^ EXP;
    cnt  = 0;
    fv   = 1'b0;
    idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) begin
        cnt++;
        if (!fv) begin
          fv  = 1'b1;
          idx = 4'(i);
        end
      end
    end
    return {t, 5'(cnt), fv, idx, (diff == 16'd0)};
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_vec"},  32'(o_vec),  32'd0);
    check({pfx, "_busy"}, 32'(o_busy), 32'd0);
    check({pfx, "_done"}, 32'(o_done), 32'd0);
    check({pfx, "_cap"},  32'(o_cap),  32'd0);
    check({pfx, "_pass"}, 32'(o_pass), 32'd0);
    check({pfx, "_mc"},   32'(o_mc),   32'd0);
    check({pfx, "_fv"},   32'(o_fv),   32'd0);
    check({pfx, "_fi"},   32'(o_fi),   32'd0);
    check({pfx, "_st"},   32'(o_st),   32'd0);
  endtask

  task automatic check_results();
    logic [26:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("res_cap",  32'(o_cap),  32'(e[26:11]));
      check("res_mc",   32'(o_mc),   32'(e[10:6]));
      check("res_fv",   32'(o_fv),   32'(e[5]));
      check("res_fi",   32'(o_fi),   32'(e[4:1]));
      check("res_pass", 32'(o_pass), 32'(e[0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Call at a negedge. If start is already high (held over from a DONE
  // cycle), the next edge is the accepting edge t0.
  task automatic run_sweep(input bit s_sel, input logic [15:0] t, input bit hold, input bit noise);
    int s;
    int total;
    s     = s_sel ? 1 : 4;
    total = 16 * s;
    sel   = s_sel;
    tbl   = t;
    exp_q.push_back(model(t));
    start_r = 1'b1;
    @(negedge clk);                       // edge t0 has passed
    if (!hold) start_r = 1'b0;
    check("acc_busy", 32'(o_busy), 32'd1);
    check("acc_vec",  32'(o_vec),  32'd0);
    check("acc_done", 32'(o_done), 32'd0);
    check("acc_cap",  32'(o_cap),  32'd0);
    check("acc_mc",   32'(o_mc),   32'd0);
    check("acc_fv",   32'(o_fv),   32'd0);
    check("acc_pass", 32'(o_pass), 32'd0);
    check("acc_st",   32'(o_st),   32'd1);
    for (int k = 1; k <= total; k++) begin
      // start set here affects edge k, which is always mid-sweep
      if (noise && !hold) start_r = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k < total) begin
        check("run_vec",  32'(o_vec),  32'(k / s));
        check("run_busy", 32'(o_busy), 32'd1);
        check("run_done", 32'(o_done), 32'd0);
      end else begin
        check("end_done", 32'(o_done), 32'd1);
        check("end_busy", 32'(o_busy), 32'd0);
        check("end_vec",  32'(o_vec),  32'd15);
        check("end_st",   32'(o_st),   32'd2);
        check_results();
      end
    end
    if (!hold) begin
      start_r = 1'b0;
      @(negedge clk);
      check("post_done", 32'(o_done), 32'd0);
      check("post_busy", 32'(o_busy), 32'd0);
      check("post_st",   32'(o_st),   32'd0);
      check("post_vec",  32'(o_vec),  32'd15);
      check("post_cap",  32'(o_cap),  32'(t));
    end
  endtask

  task automatic reset_mid_sweep();
    sel     = 1'b0;
    tbl     = EXP;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int k = 1; k <= 29; k++) @(negedge clk);
    check("mid_vec", 32'(o_vec), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mrst");
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("mrst_nodone", 32'(o_done), 32'd0);
      check("mrst_nobusy", 32'(o_busy), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] t4a;
    rst     = 1'b1;
    start_r = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_all_zero("rst4");
      sel = 1'b1;
      check_all_zero("rst1");
      sel = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    run_sweep(1'b0, EXP, 1'b0, 1'b0);             // correct function
    run_sweep(1'b0, 16'h0000, 1'b0, 1'b0);        // f_in tied low
    t4a = ~EXP;
    t4a[2] = EXP[2];
    run_sweep(1'b0, t4a, 1'b0, 1'b0);             // inverted, bit 2 correct
    run_sweep(1'b0, EXP ^ 16'h0400, 1'b0, 1'b0);  // vec 10 inverted

    run_sweep(1'b0, EXP ^ 16'h8001, 1'b1, 1'b0);  // start held: back-to-back
    run_sweep(1'b0, EXP, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++)
      run_sweep(1'b0, 16'($urandom), 1'b0, 1'b1); // random table + start noise

    reset_mid_sweep();
    run_sweep(1'b1, EXP, 1'b0, 1'b0);             // SETTLE_CYCLES=1
    run_sweep(1'b1, 16'($urandom), 1'b0, 1'b1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
